anti_theft_fsm_multi: RTL and testbench

ANTI_THEFT_FSM_MULTI -- requirements
Module: anti_theft_fsm_multi

---
 rtl/anti_theft_fsm_multi.sv | 222 ++++++++++++++++++++++
 tb/tb_anti_theft_fsm_multi.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anti_theft_fsm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : anti_theft_fsm_multi
//  Purpose  : Vehicle anti-theft controller with programmable entry, arming
//             and alarm-hold delays. The design has one driver door (door[0])
//             and NUM_DOORS-1 passenger doors.
//  Ports    : clock        - rising-edge clock, the only clock
//             reset        - synchronous, active-high
//             ignition     - 1 = key on
//             door         - 1 = door open, one bit per door
//             reprogram    - one-cycle write strobe for a delay register
//             timeParamSel - 0 T_ARM, 1 T_DRIVER, 2 T_PASSENGER, 3 T_ALARM
//             timeValue    - new delay in seconds
//             status       - status LED
//             siren        - siren drive
//             timerActive  - countdown running
//             expired      - one-cycle pulse when the countdown ends
//             state        - current FSM state
//             nextState    - next FSM state (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module anti_theft_fsm_multi #(
  parameter int NUM_DOORS    = 2,
  parameter int TIMER_W      = 4,
  parameter int CLKS_PER_SEC = 4,
  parameter int T_ARM        = 6,
  parameter int T_DRIVER     = 8,
  parameter int T_PASSENGER  = 15,
  parameter int T_ALARM      = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ignition,
  input  logic [NUM_DOORS-1:0] door,
  input  logic                 reprogram,
  input  logic [1:0]           timeParamSel,
  input  logic [TIMER_W-1:0]   timeValue,
  output logic                 status,
  output logic                 siren,
  output logic                 timerActive,
  output logic                 expired,
  output logic [2:0]           state,
  output logic [2:0]           nextState
);

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;

  localparam logic [1:0] c_SEL_ARM = 2'd0;
  localparam logic [1:0] c_SEL_DRV = 2'd1;
  localparam logic [1:0] c_SEL_PAS = 2'd2;
  localparam logic [1:0] c_SEL_ALM = 2'd3;

  typedef enum logic [2:0] {
    S_ARMED      = 3'd0,
    S_TRIGGERED  = 3'd1,
    S_ALARM      = 3'd2,
    S_ALARM_HOLD = 3'd3,
    S_DISARMED   = 3'd4,
    S_WAIT_OPEN  = 3'd5,
    S_WAIT_CLOSE = 3'd6,
    S_ARM_DELAY  = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   delay_q [4];
  logic [TIMER_W-1:0]   count_q;
  logic [PW-1:0]        tpre_q;
  logic [PW-1:0]        free_q;
  logic                 active_q;
  logic                 expired_q;
  logic                 status_q, status_d;
  logic                 siren_q;

  logic                 load_d;
  logic                 cancel_d;
  logic [1:0]           load_sel_d;
  logic                 w_any_door;
  logic                 w_free_tick;
  logic                 w_tmr_tick;
  logic [TIMER_W-1:0]   w_load_raw;
  logic [TIMER_W-1:0]   w_load_val;

  assign w_any_door  = |door;
  assign w_free_tick = (free_q == PW'(CLKS_PER_SEC - 1));
  assign w_tmr_tick  = (tpre_q == PW'(CLKS_PER_SEC - 1));
  assign w_load_raw  = delay_q[load_sel_d];
  // A programmed zero still gives a one-second countdown.
  assign w_load_val  = (w_load_raw == '0) ? TIMER_W'(1) : w_load_raw;

  // Next-state, timer-load and timer-cancel decode.
  always_comb begin
    state_d    = state_q;
    load_d     = 1'b0;
    load_sel_d = c_SEL_ARM;
    cancel_d   = 1'b0;
    case (state_q)
      S_ARMED: begin
        if (ignition) begin
          state_d = S_DISARMED;
        end else if (w_any_door) begin
          state_d    = S_TRIGGERED;
          load_d     = 1'b1;
          load_sel_d = door[0] ? c_SEL_DRV : c_SEL_PAS;
        end
      end
      S_TRIGGERED: begin
        if (ignition)       state_d = S_DISARMED;
        else if (expired_q) state_d = S_ALARM;
      end
      S_ALARM: begin
        if (ignition) begin
          state_d = S_DISARMED;
        end else if (!w_any_door) begin
          state_d    = S_ALARM_HOLD;
          load_d     = 1'b1;
          load_sel_d = c_SEL_ALM;
        end
      end
      S_ALARM_HOLD: begin
        if (ignition)        state_d = S_DISARMED;
        else if (w_any_door) state_d = S_ALARM;
        else if (expired_q)  state_d = S_ARMED;
      end
      S_DISARMED: begin
        if (!ignition) state_d = S_WAIT_OPEN;
      end
      S_WAIT_OPEN: begin
        if (ignition)     state_d = S_DISARMED;
        else if (door[0]) state_d = S_WAIT_CLOSE;
      end
      S_WAIT_CLOSE: begin
        if (ignition) begin
          state_d = S_DISARMED;
        end else if (!w_any_door) begin
          state_d    = S_ARM_DELAY;
          load_d     = 1'b1;
          load_sel_d = c_SEL_ARM;
        end
      end
      S_ARM_DELAY: begin
        if (ignition)        state_d = S_DISARMED;
        else if (w_any_door) state_d = S_WAIT_CLOSE;
        else if (expired_q)  state_d = S_ARMED;
      end
      default: state_d = S_ARMED;
    endcase

    // Leaving a state without starting a new countdown abandons the old one,
    // so a disarm never produces a stale expiry pulse.
    if (!load_d && (state_d != state_q)) cancel_d = 1'b1;

    if (reprogram) begin
      state_d  = S_ARMED;
      load_d   = 1'b0;
      cancel_d = 1'b1;
    end

    // LED blinks only while continuously armed; entering ARMED starts dark.
    status_d = 1'b0;
    if (state_d == S_ARMED) begin
      status_d = (state_q == S_ARMED) ? (status_q ^ w_free_tick) : 1'b0;
    end else if ((state_d == S_TRIGGERED) || (state_d == S_ALARM) ||
                 (state_d == S_ALARM_HOLD)) begin
      status_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_ARMED;
      count_q    <= '0;
      tpre_q     <= '0;
      free_q     <= '0;
      active_q   <= 1'b0;
      expired_q  <= 1'b0;
      status_q   <= 1'b0;
      siren_q    <= 1'b0;
      delay_q[0] <= TIMER_W'(T_ARM);
      delay_q[1] <= TIMER_W'(T_DRIVER);
      delay_q[2] <= TIMER_W'(T_PASSENGER);
      delay_q[3] <= TIMER_W'(T_ALARM);
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      siren_q   <= (state_d == S_ALARM) || (state_d == S_ALARM_HOLD);
      free_q    <= w_free_tick ? '0 : free_q + PW'(1);
      expired_q <= 1'b0;
      if (reprogram) delay_q[timeParamSel] <= timeValue;

      if (load_d) begin
        count_q  <= w_load_val;
        tpre_q   <= '0;
        active_q <= 1'b1;
      end else if (cancel_d) begin
        count_q  <= '0;
        tpre_q   <= '0;
        active_q <= 1'b0;
      end else if (active_q) begin
        // count_q reaches zero on the edge that raises expired; the
        // following edge ends the active window.
        if (count_q == '0) begin
          active_q <= 1'b0;
        end else if (w_tmr_tick) begin
          tpre_q  <= '0;
          count_q <= count_q - TIMER_W'(1);
          if (count_q == TIMER_W'(1)) expired_q <= 1'b1;
        end else begin
          tpre_q <= tpre_q + PW'(1);
        end
      end
    end
  end

  assign state       = state_q;
  assign nextState   = state_d;
  assign status      = status_q;
  assign siren       = siren_q;
  assign timerActive = active_q;
  assign expired     = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_anti_theft_fsm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_anti_theft_fsm_multi
//  Purpose  : Self-checking bench for anti_theft_fsm_multi. Two instances
//             (2 doors and 4 doors) share stimulus; a deadline-based
//             behavioural model predicts every output each cycle, and
//             directed scenarios pin literal timings.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_anti_theft_fsm_multi;
  localparam int CPS = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ignition = 1'b0;
  logic       reprogram = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] tval = 4'd0;
  logic [3:0] door4 = 4'd0;
  logic [1:0] door2;
  assign door2 = door4[1:0];

  logic       status_a, siren_a, tact_a, exp_a;
  logic       status_b, siren_b, tact_b, exp_b;
  logic [2:0] state_a, nstate_a, state_b, nstate_b;

  int checks = 0;
  int errors = 0;

  anti_theft_fsm_multi dut_a (
    .clock(clock), .reset(reset), .ignition(ignition), .door(door2),
    .reprogram(reprogram), .timeParamSel(sel), .timeValue(tval),
    .status(status_a), .siren(siren_a), .timerActive(tact_a),
    .expired(exp_a), .state(state_a), .nextState(nstate_a)
  );

  anti_theft_fsm_multi #(.NUM_DOORS(4)) dut_b (
    .clock(clock), .reset(reset), .ignition(ignition), .door(door4),
    .reprogram(reprogram), .timeParamSel(sel), .timeValue(tval),
    .status(status_b), .siren(siren_b), .timerActive(tact_b),
    .expired(exp_b), .state(state_b), .nextState(nstate_b)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // The countdown is held as an absolute deadline edge number.
  int n = 0;
  int m_st     [2];
  int m_on     [2];
  int m_dl     [2];
  int m_stat   [2];
  int m_valid  [2] = '{0, 0};
  int m_rst    [2];
  int m_delay  [2][4];

  function automatic int fsm_next(int st, bit ign, logic [3:0] d, bit ex);
    case (st)
      0: begin if (ign) return 4; if (d != 0) return 1; return 0; end
      1: begin if (ign) return 4; if (ex) return 2; return 1; end
      2: begin if (ign) return 4; if (d == 0) return 3; return 2; end
      3: begin if (ign) return 4; if (d != 0) return 2; if (ex) return 0; return 3; end
      4: begin if (ign) return 4; return 5; end
      5: begin if (ign) return 4; if (d[0]) return 6; return 5; end
      6: begin if (ign) return 4; if (d == 0) return 7; return 6; end
      default: begin if (ign) return 4; if (d != 0) return 6; if (ex) return 0; return 7; end
    endcase
  endfunction

  function automatic bit m_exp(int i);
    return (m_on[i] != 0) && (n == m_dl[i]);
  endfunction

  function automatic bit m_act(int i);
    return (m_on[i] != 0) && (n <= m_dl[i]);
  endfunction

  task automatic model_step(input int i, input logic [3:0] d);
    int  nst;
    int  v;
    bit  ex;
    bit  tick;
    if (reset) begin
      m_st[i] = 0; m_on[i] = 0; m_dl[i] = 0; m_stat[i] = 0;
      m_delay[i][0] = 6; m_delay[i][1] = 8; m_delay[i][2] = 15; m_delay[i][3] = 10;
      m_rst[i] = n; m_valid[i] = 1;
      return;
    end
    if (m_valid[i] == 0) return;
    ex   = (m_on[i] != 0) && ((n - 1) == m_dl[i]);
    tick = ((n - m_rst[i]) % CPS) == 0;
    nst  = fsm_next(m_st[i], ignition, d, ex);
    if (reprogram) begin
      m_delay[i][sel] = int'(tval);
      nst = 0;
      m_on[i] = 0;
    end else if (nst != m_st[i]) begin
      if (nst == 1 || nst == 3 || nst == 7) begin
        if (nst == 1)      v = d[0] ? m_delay[i][1] : m_delay[i][2];
        else if (nst == 3) v = m_delay[i][3];
        else               v = m_delay[i][0];
        if (v == 0) v = 1;
        m_on[i] = 1;
        m_dl[i] = n + v * CPS;
      end else begin
        m_on[i] = 0;
      end
    end
    if (nst == 0)                m_stat[i] = (m_st[i] == 0) ? (m_stat[i] ^ int'(tick)) : 0;
    else if (nst >= 1 && nst <= 3) m_stat[i] = 1;
    else                         m_stat[i] = 0;
    m_st[i] = nst;
  endtask

  always @(posedge clock) begin
    n = n + 1;
    model_step(0, door4 & 4'h3);
    model_step(1, door4);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int expv);
    checks = checks + 1;
    if (act != expv) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic cmp(input int i, input logic [2:0] s, input logic [2:0] ns,
                     input logic stv, input logic sir, input logic ta, input logic ex);
    logic [3:0] d;
    int ens;
    d   = (i == 0) ? (door4 & 4'h3) : door4;
    ens = reprogram ? 0 : fsm_next(m_st[i], ignition, d, m_exp(i));
    chk($sformatf("m%0d_state", i), int'(s), m_st[i]);
    chk($sformatf("m%0d_nextState", i), int'(ns), ens);
    chk($sformatf("m%0d_status", i), int'(stv), m_stat[i]);
    chk($sformatf("m%0d_siren", i), int'(sir), (m_st[i] == 2 || m_st[i] == 3) ? 1 : 0);
    chk($sformatf("m%0d_timerActive", i), int'(ta), int'(m_act(i)));
    chk($sformatf("m%0d_expired", i), int'(ex), int'(m_exp(i)));
  endtask

  always @(posedge clock) begin
    #1;
    if (m_valid[0] != 0) cmp(0, state_a, nstate_a, status_a, siren_a, tact_a, exp_a);
    if (m_valid[1] != 0) cmp(1, state_b, nstate_b, status_b, siren_b, tact_b, exp_b);
  end

  // Cycles from now until the expired pulse is seen (0 if it never comes).
  task automatic wait_exp(input bit use_b, output int k);
    k = 0;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clock);
      if (use_b ? exp_b : exp_a) begin
        k = j;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // DISARMED -> WAIT_OPEN -> WAIT_CLOSE -> ARM_DELAY.
  task automatic go_arm_delay();
    ignition = 1'b1; @(negedge clock);
    ignition = 1'b0; @(negedge clock);
    door4 = 4'b1001; @(negedge clock);
    door4 = 4'b0000; @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int seen;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_state", int'(state_a), 0);
    chk("rst_siren", int'(siren_a), 0);
    chk("rst_status", int'(status_a), 0);
    chk("rst_timerActive", int'(tact_a), 0);
    repeat (3) @(negedge clock);
    chk("status_before_tick", int'(status_a), 0);
    @(negedge clock);
    chk("status_after_tick", int'(status_a), 1);

    // Driver door entry delay.
    door4 = 4'b0001; @(negedge clock);
    chk("drv_triggered", int'(state_a), 1);
    chk("drv_timerActive", int'(tact_a), 1);
    wait_exp(1'b0, k);
    chk("drv_delay_cycles", k, 32);
    @(negedge clock);
    chk("drv_alarm", int'(state_a), 2);
    chk("drv_siren", int'(siren_a), 1);
    chk("model_pin_alarm", m_st[0], 2);

    // Alarm hold, interrupted by a reopened door, then re-arm.
    door4 = 4'b0000; @(negedge clock);
    chk("hold_state", int'(state_a), 3);
    repeat (19) @(negedge clock);
    door4 = 4'b0010; @(negedge clock);
    chk("hold_reopen_alarm", int'(state_a), 2);
    chk("hold_cancel_timer", int'(tact_a), 0);
    door4 = 4'b0000; @(negedge clock);
    chk("hold_again", int'(state_a), 3);
    wait_exp(1'b0, k);
    chk("hold_delay_cycles", k, 40);
    @(negedge clock);
    chk("hold_rearmed", int'(state_a), 0);
    chk("hold_siren_off", int'(siren_a), 0);

    // Passenger entry, disarmed by the key mid-countdown.
    door4 = 4'b0010; @(negedge clock);
    chk("pas_triggered", int'(state_a), 1);
    chk("model_pin_deadline", m_dl[0] - n, 60);
    door4 = 4'b0000;
    repeat (29) @(negedge clock);
    ignition = 1'b1; @(negedge clock);
    chk("pas_disarmed", int'(state_a), 4);
    chk("pas_siren", int'(siren_a), 0);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      seen = seen | int'(exp_a);
    end
    chk("pas_no_expiry", seen, 0);

    // Arming sequence; passenger door alone is ignored in WAIT_OPEN.
    ignition = 1'b0; @(negedge clock);
    chk("wo_state", int'(state_a), 5);
    door4 = 4'b0010;
    repeat (5) @(negedge clock);
    chk("wo_passenger_ignored", int'(state_a), 5);
    door4 = 4'b0001; @(negedge clock);
    chk("wc_state", int'(state_a), 6);
    door4 = 4'b0000; @(negedge clock);
    chk("ad_state", int'(state_a), 7);
    wait_exp(1'b0, k);
    chk("arm_delay_cycles", k, 24);
    @(negedge clock);
    chk("armed_after_delay", int'(state_a), 0);

    // Reprogram during alarm forces ARMED; new driver delay used afterwards.
    door4 = 4'b0001; @(negedge clock);
    wait_exp(1'b0, k);
    @(negedge clock);
    chk("rp_in_alarm", int'(state_a), 2);
    reprogram = 1'b1; sel = 2'd1; tval = 4'd2; door4 = 4'b0000;
    @(negedge clock);
    reprogram = 1'b0;
    chk("rp_armed", int'(state_a), 0);
    chk("rp_siren", int'(siren_a), 0);
    chk("rp_timer_cancel", int'(tact_a), 0);
    @(negedge clock);
    door4 = 4'b0001; @(negedge clock);
    chk("rp_triggered", int'(state_a), 1);
    wait_exp(1'b0, k);
    chk("rp_new_drv_delay", k, 8);
    @(negedge clock);
    door4 = 4'b0000;
    do_reset();

    // Four-door instance: zero delay, then reset restores T_ARM.
    reprogram = 1'b1; sel = 2'd0; tval = 4'd0; @(negedge clock);
    reprogram = 1'b0;
    go_arm_delay();
    chk("d4_arm_delay_state", int'(state_b), 7);
    wait_exp(1'b1, k);
    chk("d4_zero_as_one", k, 4);
    @(negedge clock);
    chk("d4_armed", int'(state_b), 0);
    go_arm_delay();
    repeat (2) @(negedge clock);
    do_reset();
    chk("d4_reset_armed", int'(state_b), 0);
    chk("d4_reset_timer", int'(tact_b), 0);
    go_arm_delay();
    wait_exp(1'b1, k);
    chk("d4_restored_t_arm", k, 24);
    @(negedge clock);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      reprogram = 1'b0;
      reset     = 1'b0;
      if ($urandom_range(0, 39) == 0) ignition = ~ignition;
      if ($urandom_range(0, 7) == 0)
        door4 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        reprogram = 1'b1;
        sel  = 2'($urandom_range(0, 3));
        tval = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 399) == 0) reset = 1'b1;
    end
    @(negedge clock);
    reprogram = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
